// File: rtl/bitmanip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bitmanip_pkg                                                |
// | Desc   : Shared types and helpers for the butterfly mask decoder.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package bitmanip_pkg;

  localparam int XLEN   = 32;
  localparam int NSTAGE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [15:0] cfg_word_t;

  // One 6-bit count slot per mask bit; only the low 32>>s slots are live at stage s.
  typedef logic [XLEN-1:0][5:0] cnt_vec_t;

  function automatic cfg_word_t lrotc_fill(input logic [5:0] k, input logic [4:0] h);
    logic [5:0]  kk;
    logic [16:0] t;
    kk = (k > {1'b0, h}) ? {1'b0, h} : k;
    t  = (17'd1 << kk) - 17'd1;
    return t[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bfly_stage_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bfly_stage_gen                                              |
// | Desc   : One inverse-butterfly stage: block counts and control word.|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module bfly_stage_gen
  import bitmanip_pkg::*;
(
  input  logic [2:0] stage,
  input  cnt_vec_t   prev_cnt,
  output cnt_vec_t   next_cnt,
  output cfg_word_t  ib_word
);

  logic [4:0] w_half;

  assign w_half = 5'd1 << stage;

  // Stage 0 passes the per-bit counts through; later stages merge adjacent pairs.
  always_comb begin
    next_cnt = '0;
    if (stage == 3'd0) begin
      next_cnt = prev_cnt;
    end else begin
      for (int j = 0; j < XLEN / 2; j++) begin
        next_cnt[j] = prev_cnt[2*j] + prev_cnt[2*j+1];
      end
    end
  end

  // Block b reads the count of its lower half, which sits at even slot 2*b.
  always_comb begin
    logic [4:0] blk2;
    logic [3:0] off;
    cfg_word_t  fill;
    blk2    = '0;
    off     = '0;
    fill    = '0;
    ib_word = '0;
    for (int p = 0; p < 16; p++) begin
      blk2       = 5'((p >> stage) << 1);
      off        = 4'(p) & 4'(w_half - 5'd1);
      fill       = lrotc_fill(next_cnt[blk2], w_half);
      ib_word[p] = fill[off];
    end
  end

endmodule
`default_nettype wire

// File: rtl/bfly_mask_decoder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bfly_mask_decoder_seq                                       |
// | Desc   : Sequential pdep/pext butterfly config decoder, 1-entry cache|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module bfly_mask_decoder_seq
  import bitmanip_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_mask,
  input  logic            req_dir,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [15:0]     cfg0,
  output logic [15:0]     cfg1,
  output logic [15:0]     cfg2,
  output logic [15:0]     cfg3,
  output logic [15:0]     cfg4,
  output logic [5:0]      pcnt
);

  state_t          r_state;
  logic [2:0]      r_stage;
  logic [XLEN-1:0] r_mask;
  logic            r_dir;
  cnt_vec_t        r_cnt;
  cfg_word_t       r_ib [NSTAGE];
  logic            r_cache_valid;
  logic [XLEN-1:0] r_cache_mask;
  logic [5:0]      r_cache_pcnt;

  cnt_vec_t        w_prev;
  cnt_vec_t        w_next;
  cfg_word_t       w_ib_word;
  cfg_word_t       w_ib_full [NSTAGE];
  cfg_word_t       w_src [NSTAGE];
  cfg_word_t       w_cfg [NSTAGE];
  logic            w_dir;
  logic            w_hit;
  logic [5:0]      w_pcnt;

  bfly_stage_gen u_stage_gen (
    .stage    (r_stage),
    .prev_cnt (w_prev),
    .next_cnt (w_next),
    .ib_word  (w_ib_word)
  );

  always_comb begin
    w_prev = r_cnt;
    if (r_stage == 3'd0) begin
      for (int j = 0; j < XLEN; j++) begin
        w_prev[j] = {5'd0, r_mask[j]};
      end
    end
  end

  // The last stage leaves the two 16-bit half counts in slots 0 and 1.
  assign w_pcnt = w_next[0] + w_next[1];
  assign w_hit  = r_cache_valid && (req_mask == r_cache_mask);

  // A hit reorders the cached words by the incoming dir; a miss uses the latched dir
  // and folds in the word being produced this cycle.
  always_comb begin
    w_dir = (r_state == IDLE) ? req_dir : r_dir;
    for (int i = 0; i < NSTAGE; i++) begin
      w_ib_full[i] = (3'(i) == r_stage) ? w_ib_word : r_ib[i];
    end
    for (int i = 0; i < NSTAGE; i++) begin
      w_src[i] = (r_state == CALC) ? w_ib_full[i] : r_ib[i];
    end
    for (int i = 0; i < NSTAGE; i++) begin
      w_cfg[i] = w_dir ? w_src[NSTAGE-1-i] : w_src[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_stage       <= 3'd0;
      r_mask        <= '0;
      r_dir         <= 1'b0;
      r_cnt         <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        r_ib[i] <= '0;
      end
      r_cache_valid <= 1'b0;
      r_cache_mask  <= '0;
      r_cache_pcnt  <= '0;
      cfg0          <= '0;
      cfg1          <= '0;
      cfg2          <= '0;
      cfg3          <= '0;
      cfg4          <= '0;
      pcnt          <= '0;
      resp_valid    <= 1'b0;
      req_ready     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_mask    <= req_mask;
            r_dir     <= req_dir;
            req_ready <= 1'b0;
            if (w_hit) begin
              cfg0       <= w_cfg[0];
              cfg1       <= w_cfg[1];
              cfg2       <= w_cfg[2];
              cfg3       <= w_cfg[3];
              cfg4       <= w_cfg[4];
              pcnt       <= r_cache_pcnt;
              resp_valid <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_stage <= 3'd0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_cnt          <= w_next;
          r_ib[r_stage]  <= w_ib_word;
          if (r_stage == 3'(NSTAGE - 1)) begin
            r_cache_mask  <= r_mask;
            r_cache_valid <= 1'b1;
            r_cache_pcnt  <= w_pcnt;
            pcnt          <= w_pcnt;
            cfg0          <= w_cfg[0];
            cfg1          <= w_cfg[1];
            cfg2          <= w_cfg[2];
            cfg3          <= w_cfg[3];
            cfg4          <= w_cfg[4];
            resp_valid    <= 1'b1;
            r_stage       <= 3'd0;
            r_state       <= DONE;
          end else begin
            r_stage <= r_stage + 3'd1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bfly_mask_decoder_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_bfly_mask_decoder_seq                                    |
// | Desc   : Directed self-checking bench with a stage-rule model.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bfly_mask_decoder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_mask = '0;
  logic        req_dir = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] cfg0, cfg1, cfg2, cfg3, cfg4;
  logic [5:0]  pcnt;

  bfly_mask_decoder_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mask   (req_mask),
    .req_dir    (req_dir),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .cfg0       (cfg0),
    .cfg1       (cfg1),
    .cfg2       (cfg2),
    .cfg3       (cfg3),
    .cfg4       (cfg4),
    .pcnt       (pcnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [4:0][15:0] exp_cfg = '0;
  logic [5:0]       exp_pcnt = '0;
  bit               exp_active = 1'b0;
  bit               m_cache_valid = 1'b0;
  logic [31:0]      m_cache_mask = '0;
  logic [4:0][15:0] dut_cfg;

  assign dut_cfg = {cfg4, cfg3, cfg2, cfg1, cfg0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Direct statement of the decoding rule: count the lower half of every block.
  function automatic void model(input logic [31:0] m, input logic d,
                                output logic [4:0][15:0] c, output logic [5:0] p);
    logic [4:0][15:0] ib;
    int h, w, k;
    ib = '0;
    for (int s = 0; s < 5; s++) begin
      h = 1 << s;
      w = 2 * h;
      for (int b = 0; b < 32 / w; b++) begin
        k = 0;
        for (int i = 0; i < h; i++) k += int'(m[b*w+i]);
        ib[s] = ib[s] | 16'(((1 << k) - 1) << (b * h));
      end
    end
    p = 6'($countones(m));
    for (int i = 0; i < 5; i++) c[i] = d ? ib[4-i] : ib[i];
  endfunction

  always @(negedge clk) begin
    if (!rst && resp_valid && exp_active) begin
      check("cmp_cfg0", 32'(cfg0), 32'(exp_cfg[0]));
      check("cmp_cfg1", 32'(cfg1), 32'(exp_cfg[1]));
      check("cmp_cfg2", 32'(cfg2), 32'(exp_cfg[2]));
      check("cmp_cfg3", 32'(cfg3), 32'(exp_cfg[3]));
      check("cmp_cfg4", 32'(cfg4), 32'(exp_cfg[4]));
      check("cmp_pcnt", 32'(pcnt), 32'(exp_pcnt));
      check("cmp_req_ready_low", 32'(req_ready), 32'd0);
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge where resp_valid is seen.
  task automatic start_req(input logic [31:0] m, input logic d);
    int n;
    int exp_lat;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    model(m, d, exp_cfg, exp_pcnt);
    exp_active = 1'b1;
    exp_lat = (m_cache_valid && m == m_cache_mask) ? 1 : 6;
    req_valid = 1'b1;
    req_mask  = m;
    req_dir   = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_mask  = $urandom;
    req_dir   = ~d;
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    m_cache_valid = 1'b1;
    m_cache_mask  = m;
  endtask

  task automatic finish_req(input int hold);
    logic [4:0][15:0] snap;
    snap = dut_cfg;
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
      end
      check("hold_stable", 32'(dut_cfg == snap), 32'd1);
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_active = 1'b0;
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic lit(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                     input logic [15:0] c3, input logic [15:0] c4, input logic [5:0] p);
    check("lit_cfg0", 32'(cfg0), 32'(c0));
    check("lit_cfg1", 32'(cfg1), 32'(c1));
    check("lit_cfg2", 32'(cfg2), 32'(c2));
    check("lit_cfg3", 32'(cfg3), 32'(c3));
    check("lit_cfg4", 32'(cfg4), 32'(c4));
    check("lit_pcnt", 32'(pcnt), 32'(p));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cfg"}, 32'(dut_cfg != '0), 32'd0);
    check({tag, "_pcnt"}, 32'(pcnt), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_zero_outputs("post_reset");

    start_req(32'h0000FFFF, 1'b0);
    lit(16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'hFFFF, 6'd16);
    finish_req(0);

    start_req(32'h0000FFFF, 1'b1);
    lit(16'hFFFF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 6'd16);
    finish_req(0);

    start_req(32'hAAAAAAAA, 1'b0);
    lit(16'h0000, 16'h5555, 16'h3333, 16'h0F0F, 16'h00FF, 6'd16);
    finish_req(0);

    start_req(32'h00000001, 1'b1);
    lit(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 6'd1);
    finish_req(0);

    start_req(32'h00000000, 1'b0);
    lit(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 6'd0);
    finish_req(0);

    start_req(32'hFFFFFFFF, 1'b0);
    lit(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'd32);
    finish_req(10);

    start_req(32'h12345678, 1'b1);
    finish_req(2);
    start_req(32'hF0F00F0F, 1'b0);
    finish_req(0);
    start_req(32'hF0F00F0F, 1'b1);
    finish_req(0);
    start_req(32'hFFFFFFFF, 1'b1);
    finish_req(0);

    // Abort a miss partway through stage 2 with an asynchronous reset.
    req_valid = 1'b1;
    req_mask  = 32'hDEADBEEF;
    req_dir   = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    exp_active = 1'b0;
    #1;
    check_zero_outputs("mid_calc_reset");
    m_cache_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    start_req(32'hFFFFFFFF, 1'b0);
    finish_req(0);
    start_req(32'hDEADBEEF, 1'b1);
    finish_req(0);
    start_req(32'hDEADBEEF, 1'b0);
    finish_req(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bfly_mask_decoder_seq.md
# bfly_mask_decoder_seq

Sequential mask decoder for the bit-manipulation unit. It accepts a 32-bit mask and produces the five 16-bit butterfly-network control words. In deposit mode (pdep) the words come out in butterfly order; in extract mode (pext) they come out in inverse-butterfly order. One stage is computed per cycle, so a single shared stage-config generator replaces the fully combinational popcount tree. A one-entry mask cache returns repeated masks with 1-cycle latency.

## Interface
- XLEN, 32: mask width; fixed, only 32 is supported.
- NSTAGE, 5: network stages, log2(XLEN).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_mask  in  32  bitmask.
- req_dir  in  1  output order: 0 = extract (inverse-butterfly order), 1 = deposit (butterfly order).
- resp_valid  out  1  config words valid.
- resp_ready  in  1  consumer takes the response.
- cfg0..cfg4  out  16 each  stage control words, cfg0 = first stage traversed.
- pcnt  out  6  popcount of the mask, 0..32.

## Operation
- Decoding rule, with s = 0..4 as the inverse-butterfly stage index:
  - Block width w = 2^(s+1), half width h = 2^s; there are 32/w blocks.
  - For block b, k = popcount of mask bits [b*w +: h], the lower half of the block.
  - The block's h control bits are LROTC(0, k) = (1<<k)-1, with k ≤ h.
  - These bits land at ib[s][b*h +: h].
- Counts are held in a per-block count register that is updated each stage:
  - Stage 0 loads the 1-bit counts of the mask.
  - Stage s sums adjacent pairs of the stage s-1 counts.
  - Count width grows by one bit per stage. No overflow is possible.
- Output order:
  - req_dir=0: cfg_i = ib[i].
  - req_dir=1: cfg_i = ib[4-i] (stage reversal for deposit).
- The direction is latched at accept. It only reorders outputs and does not affect cache lookup.
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, latch mask and dir, then:
    - if cache_valid && mask==cache_mask, go to DONE (hit);
    - otherwise, stage:=0 and go to CALC.
  - CALC: compute stage `stage`, write ib[stage], then stage++.
    - After stage 4: write cache_mask, set cache_valid=1, compute pcnt, go to DONE.
  - DONE: resp_valid=1. Outputs are held stable while resp_ready=0. On resp_ready, go to IDLE.
- req_ready is high only in IDLE, so there is no accept in the same cycle as a response handshake.
- The cache holds the ib[] words and pcnt for the last fully computed mask. A hit reuses them with the newly latched dir.

## Timing
- Accept edge E0. Miss: CALC runs during cycles 1..5 and resp_valid is high from cycle 6 (6-cycle latency). Hit: resp_valid is high from cycle 1.
- Minimum turnaround: the response handshake edge returns to IDLE; the next accept can happen one cycle later.
- Reset is asynchronous and may occur in any state. All of the following take effect immediately:
  - state=IDLE, stage=0;
  - cfg0..4=0, pcnt=0, resp_valid=0, req_ready=1 (after reset deasserts);
  - cache_valid=0.
- Reset during CALC discards the partial result. The cache is not updated.
- req_valid/req_mask changing while the block is not in IDLE is ignored.
- Mask 0 is a legal input and produces all-zero words. Mask 0xFFFFFFFF produces all-0xFFFF words and pcnt=32.

## Structure
- Package bitmanip_pkg holds:
  - XLEN, NSTAGE;
  - the typedef enum of FSM states {IDLE, CALC, DONE};
  - the cfg word typedef logic [15:0];
  - the function lrotc_fill(k, h).
- Sub-module bfly_stage_gen (combinational):
  - inputs: stage index and the previous count vector;
  - outputs: the next count vector and the 16-bit ib word;
  - instantiated once and reused across all five cycles.

## Test plan
- Mask 0x0000FFFF, dir=0, miss:
  - ib cfg0..3=0x00FF, cfg4=0xFFFF, pcnt=16;
  - resp_valid high exactly 6 cycles after accept.
- Same mask with dir=1 → hit in 1 cycle; cfg0=0xFFFF, cfg1..4=0x00FF.
- Mask 0xAAAAAAAA, dir=0 → cfg0=0x0000, cfg1=0x5555, cfg2=0x3333, cfg3=0x0F0F, cfg4=0x00FF, pcnt=16.
- Boundary masks:
  - 0x00000001 → all cfg=0x0001, pcnt=1.
  - 0x00000000 → all cfg=0, pcnt=0.
  - 0xFFFFFFFF → all cfg=0xFFFF, pcnt=32.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid and outputs stay stable and req_ready stays 0. Release → IDLE on the next cycle.
- Reset mid-CALC at stage 2:
  - all outputs are 0 immediately;
  - re-issuing the previous mask is a miss with 6-cycle latency.
